// File: rtl/block_rate_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// rdoq_rate_pkg
// Shared types and helpers for the block rate accumulator.
//   level_case_e : level class of one RDOQ candidate (ZERO costs nothing)
//   acc_state_e  : block FSM states
//   sat_sum_t    : saturating-add result, value plus a "clamped" flag
//   sat_add()    : unsigned add clamped to an arbitrary width w < SAT_MAX_W
//   sel_width()  : width of a candidate index for n candidates
// ---------------------------------------------------------------------------
package rdoq_rate_pkg;

    typedef enum logic [1:0] {
        LVL_ZERO = 2'd0,
        LVL_ONE  = 2'd1,
        LVL_TWO  = 2'd2,
        LVL_GT2  = 2'd3
    } level_case_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } acc_state_e;

    // Widest operand sat_add handles; the clamp width w must stay below it.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] sum;
    } sat_sum_t;

    // Adds a and b with one guard bit and clamps to 2^w-1. Because the
    // clamp width is a run-time argument, one function serves every
    // accumulator width in the design.
    function automatic sat_sum_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                         input logic [SAT_MAX_W-1:0] b,
                                         input int unsigned          w);
        logic [SAT_MAX_W:0] full;
        logic [SAT_MAX_W:0] limit;
        sat_sum_t           r;
        full  = {1'b0, a} + {1'b0, b};
        limit = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        if (full > limit) begin
            r.sat = 1'b1;
            r.sum = limit[SAT_MAX_W-1:0];
        end else begin
            r.sat = 1'b0;
            r.sum = full[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

    // A single candidate still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_rate_accumulator_if.sv
// ---------------------------------------------------------------------------
// block_rate_accumulator_if
// Bundles the coefficient-beat input channel, the per-candidate rate output
// and the block-result handshake of block_rate_accumulator.
//   master : producer/consumer side (drives in_*, blk_ready)
//   slave  : accumulator side (drives in_ready, cand_*, blk_* results)
// Signals:
//   in_valid/in_ready      beat handshake
//   in_sign_bits/suffix/ctx per-candidate costs, candidate 0 in the LSBs
//   in_level_case          2 bits per candidate (level_case_e)
//   in_sel, in_last        chosen candidate, last beat of the block
//   cand_valid, cand_rate  registered per-candidate rates of the last beat
//   blk_valid/blk_ready    block result handshake
//   blk_rate, blk_count    block total and beat count
//   blk_sat, blk_err       saturation / error flags
// ---------------------------------------------------------------------------
interface block_rate_accumulator_if
    import rdoq_rate_pkg::*;
#(
    parameter int NUM_CAND   = 3,
    parameter int RATE_W     = 32,
    parameter int ACC_W      = 40,
    parameter int MAX_COEFFS = 1024,
    parameter int CNT_W      = $clog2(MAX_COEFFS + 1),
    parameter int SEL_W      = sel_width(NUM_CAND)
);

    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CAND*RATE_W-1:0] in_sign_bits;
    logic [NUM_CAND*RATE_W-1:0] in_suffix_bits;
    logic [NUM_CAND*RATE_W-1:0] in_ctx_bits;
    logic [NUM_CAND*2-1:0]      in_level_case;
    logic [SEL_W-1:0]           in_sel;
    logic                       in_last;

    logic                       cand_valid;
    logic [NUM_CAND*RATE_W-1:0] cand_rate;

    logic                       blk_valid;
    logic                       blk_ready;
    logic [ACC_W-1:0]           blk_rate;
    logic [CNT_W-1:0]           blk_count;
    logic                       blk_sat;
    logic                       blk_err;

    modport master (
        output in_valid, in_sign_bits, in_suffix_bits, in_ctx_bits,
               in_level_case, in_sel, in_last, blk_ready,
        input  in_ready, cand_valid, cand_rate,
               blk_valid, blk_rate, blk_count, blk_sat, blk_err
    );

    modport slave (
        input  in_valid, in_sign_bits, in_suffix_bits, in_ctx_bits,
               in_level_case, in_sel, in_last, blk_ready,
        output in_ready, cand_valid, cand_rate,
               blk_valid, blk_rate, blk_count, blk_sat, blk_err
    );

endinterface

// File: rtl/block_rate_accumulator_cand_sum.sv
// ---------------------------------------------------------------------------
// rate_cand_sum
// Combinational rate of one RDOQ candidate level.
//   sign_i, suffix_i, ctx_i : bit-cost components (RATE_W each)
//   level_case_i            : level class; LVL_ZERO costs nothing
//   rate_o                  : sign + suffix + ctx clamped to all-ones
//   sat_o                   : the clamp was applied
// ---------------------------------------------------------------------------
module rate_cand_sum
    import rdoq_rate_pkg::*;
#(
    parameter int RATE_W = 32
) (
    input  logic [RATE_W-1:0] sign_i,
    input  logic [RATE_W-1:0] suffix_i,
    input  logic [RATE_W-1:0] ctx_i,
    input  level_case_e       level_case_i,
    output logic [RATE_W-1:0] rate_o,
    output logic              sat_o
);

    // Two guard bits hold the carry of a three-operand sum.
    logic [RATE_W+1:0] wide_sum;

    always_comb begin
        wide_sum = {2'b00, sign_i} + {2'b00, suffix_i} + {2'b00, ctx_i};
        rate_o   = '0;
        sat_o    = 1'b0;
        // A ZERO level is never coded, so its components are irrelevant
        // and cannot raise the saturation flag either.
        if (level_case_i != LVL_ZERO) begin
            if (|wide_sum[RATE_W+1:RATE_W]) begin
                rate_o = '1;
                sat_o  = 1'b1;
            end else begin
                rate_o = wide_sum[RATE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/block_rate_accumulator.sv
// ---------------------------------------------------------------------------
// block_rate_accumulator
// Per-beat candidate rate evaluation plus a saturating block-rate total
// for the RDOQ-selected candidate, reported once per transform block.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   clear  synchronous abort: back to IDLE, pending result dropped
//   bus    block_rate_accumulator_if.slave (beat in, cand rates, block out)
// Parameters: NUM_CAND (>= 1), RATE_W, ACC_W (>= RATE_W, < SAT_MAX_W),
//             MAX_COEFFS (beats per block before forced termination).
// ---------------------------------------------------------------------------
module block_rate_accumulator
    import rdoq_rate_pkg::*;
#(
    parameter int NUM_CAND   = 3,
    parameter int RATE_W     = 32,
    parameter int ACC_W      = 40,
    parameter int MAX_COEFFS = 1024,
    parameter int CNT_W      = $clog2(MAX_COEFFS + 1),
    parameter int SEL_W      = sel_width(NUM_CAND)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    block_rate_accumulator_if.slave  bus
);

    acc_state_e                 state_q, state_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       sat_q, sat_d;
    logic                       err_q, err_d;
    logic [NUM_CAND*RATE_W-1:0] cand_rate_q, cand_rate_d;
    logic                       cand_valid_q, cand_valid_d;

    logic [RATE_W-1:0]          cand_rate_w [NUM_CAND];
    logic                       cand_sat_w  [NUM_CAND];
    logic [NUM_CAND*RATE_W-1:0] cand_rate_flat;

    logic                       in_ready_w;
    logic                       beat;
    logic                       sel_in_range;
    logic [RATE_W-1:0]          sel_rate;
    logic                       sel_sat;
    sat_sum_t                   acc_add;
    logic                       acc_over;
    logic [CNT_W-1:0]           cnt_inc;
    logic                       at_max;

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
        rate_cand_sum #(
            .RATE_W (RATE_W)
        ) u_sum (
            .sign_i       (bus.in_sign_bits[k*RATE_W +: RATE_W]),
            .suffix_i     (bus.in_suffix_bits[k*RATE_W +: RATE_W]),
            .ctx_i        (bus.in_ctx_bits[k*RATE_W +: RATE_W]),
            .level_case_i (level_case_e'(bus.in_level_case[2*k +: 2])),
            .rate_o       (cand_rate_w[k]),
            .sat_o        (cand_sat_w[k])
        );
        assign cand_rate_flat[k*RATE_W +: RATE_W] = cand_rate_w[k];
    end

    assign in_ready_w = (state_q != OUT);
    assign beat       = bus.in_valid && in_ready_w;

    // Compare-based select: an index beyond NUM_CAND simply matches nothing,
    // which yields a zero rate and flags the beat as erroneous.
    always_comb begin
        sel_in_range = 1'b0;
        sel_rate     = '0;
        sel_sat      = 1'b0;
        for (int k = 0; k < NUM_CAND; k++) begin
            if (int'(bus.in_sel) == k) begin
                sel_in_range = 1'b1;
                sel_rate     = cand_rate_w[k];
                sel_sat      = cand_sat_w[k];
            end
        end
    end

    // The clamped sum never has bits above ACC_W set, so OR-ing them into
    // the overflow flag changes nothing while consuming the whole result.
    always_comb begin
        acc_add  = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(sel_rate), ACC_W);
        acc_over = acc_add.sat | (|acc_add.sum[SAT_MAX_W-1:ACC_W]);
    end

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign at_max  = (cnt_inc == CNT_W'(MAX_COEFFS));

    // Accumulator, count and flags are already zero whenever the FSM sits
    // in IDLE (reset, clear and the OUT handshake all zero them), so the
    // first beat of a block can build on the registers directly.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        err_d        = err_q;
        cand_rate_d  = cand_rate_q;
        cand_valid_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        cand_rate_d  = cand_rate_flat;
                        cand_valid_d = 1'b1;
                        cnt_d        = cnt_inc;
                        if (sel_in_range) begin
                            acc_d = acc_add.sum[ACC_W-1:0];
                            sat_d = sat_q | acc_over | sel_sat;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (at_max && !bus.in_last) begin
                            err_d = 1'b1;
                        end
                        state_d = (bus.in_last || at_max) ? OUT : ACCUM;
                    end
                end
                OUT: begin
                    if (bus.blk_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            err_q        <= 1'b0;
            cand_rate_q  <= '0;
            cand_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            err_q        <= err_d;
            cand_rate_q  <= cand_rate_d;
            cand_valid_q <= cand_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.cand_valid = cand_valid_q;
    assign bus.cand_rate  = cand_rate_q;
    assign bus.blk_valid  = (state_q == OUT);
    assign bus.blk_rate   = acc_q;
    assign bus.blk_count  = cnt_q;
    assign bus.blk_sat    = sat_q;
    assign bus.blk_err    = err_q;

endmodule

// File: doc/block_rate_accumulator.md
Name: block_rate_accumulator

Overview:
- Parametrised successor of the per-coefficient rate accumulator in the CABAC bit-rate estimator.
- For each coefficient beat it computes the rate of NUM_CAND candidate levels in parallel: sign + suffix + context bits, or 0 for a ZERO level.
- It also keeps a running, saturating rate total for the candidate the RDOQ decision selects.
- At the end of a transform block it emits the block total, coefficient count and error flags over a valid/ready handshake.

Parameters:
- NUM_CAND, 3: candidate levels evaluated per coefficient. Must be >= 1.
- RATE_W, 32: width of each rate component and of each candidate rate.
- ACC_W, 40: width of the block-rate accumulator. Must be >= RATE_W.
- MAX_COEFFS, 1024: maximum beats per block. CNT_W = $clog2(MAX_COEFFS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort of the current block. Returns to IDLE and drops any pending output.
- in_valid  in  1  coefficient beat valid.
- in_ready  out  1  block can accept a beat.
- in_sign_bits  in  NUM_CAND*RATE_W  per-candidate sign-bit cost, candidate 0 in the LSBs.
- in_suffix_bits  in  NUM_CAND*RATE_W  per-candidate suffix bits.
- in_ctx_bits  in  NUM_CAND*RATE_W  per-candidate context bits.
- in_level_case  in  NUM_CAND*2  per-candidate level class.
- in_sel  in  max(1,$clog2(NUM_CAND))  index of the chosen candidate.
- in_last  in  1  last coefficient of the block.
- cand_valid  out  1  cand_rate is valid, one-cycle pulse.
- cand_rate  out  NUM_CAND*RATE_W  per-candidate rate of the accepted beat.
- blk_valid  out  1  block result valid.
- blk_ready  in  1  consumer accepts the block result.
- blk_rate  out  ACC_W  total rate of the selected candidates.
- blk_count  out  CNT_W  number of beats in the block.
- blk_sat  out  1  accumulator or a candidate sum saturated during the block.
- blk_err  out  1  in_sel was out of range, or the block was force-terminated at MAX_COEFFS.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-high on port rst.
  - Reset values: all outputs 0 except in_ready = 1. State = IDLE, accumulator = 0, count = 0, flags = 0.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Candidate rate, per candidate k:
  - Rate is 0 if level_case[k] == LVL_ZERO.
  - Otherwise rate = sign + suffix + ctx, computed at RATE_W+2 bits and saturated to all-ones RATE_W.
  - cand_rate and cand_valid are registered, latency 1 from acceptance.
  - cand_rate holds its value between beats; cand_valid is high for one cycle only.
- Selected-candidate accumulation:
  - The selected rate is cand_rate[in_sel], added to the accumulator in the acceptance cycle. Result is visible with the latency-1 outputs.
  - The add is saturating: at the ceiling the accumulator clamps to 2^ACC_W-1 and blk_sat is set.
  - Any saturated candidate sum on the selected index also sets blk_sat.
  - If in_sel >= NUM_CAND, the beat adds 0, sets blk_err and still counts as a beat.
- FSM states:
  - IDLE: in_ready = 1, accumulator and flags clear. An accepted beat goes to ACCUM, or to OUT if in_last is set.
  - ACCUM: in_ready = 1. Each beat increments the count. A beat with in_last, or the beat that makes count == MAX_COEFFS, goes to OUT. A forced termination (count hits MAX_COEFFS without in_last) sets blk_err.
  - OUT: in_ready = 0, blk_valid = 1. blk_rate, blk_count and the flags are stable. On blk_ready, go to IDLE and clear the accumulator, count and flags in the same edge.
- Timing: blk_valid rises in the cycle after the last beat is accepted. blk_rate includes the last beat. Sustained throughput is 1 beat/cycle.
- The FSM does not pipeline across blocks: a new block waits for the OUT handshake to complete (in_ready = 0 in OUT).
- clear:
  - Has priority over all events; in_valid and blk_ready are ignored in that cycle.
  - Next state is IDLE with accumulator, count and flags zeroed, and blk_valid = 0.
  - cand_valid is not asserted for a beat presented in the clear cycle.
- Single-beat block (in_last on the first beat): IDLE -> OUT directly, with blk_count = 1.
- Asserting rst mid-block discards everything immediately.

Decomposition:
- Package rdoq_rate_pkg holds:
  - level_case_e: LVL_ZERO = 0, LVL_ONE = 1, LVL_TWO = 2, LVL_GT2 = 3.
  - acc_state_e: IDLE, ACCUM, OUT.
  - A sat_add function parameterised by width.
- Sub-module rate_cand_sum: combinational, one instance per candidate via generate. Inputs are the three components and the level case; outputs are the saturated rate and a sat flag.
- Top level holds the registers, FSM and accumulator.

Test Plan:
- Reset and single beat:
  - Assert rst, then release.
  - One beat: candidate 0 = (sign 1, suffix 3, ctx 5, LVL_ONE), sel 0, in_last = 1.
  - Expect cand_rate[0] = 9 with cand_valid the next cycle, then blk_valid with blk_rate = 9, blk_count = 1, flags 0.
- ZERO candidate and selection over 4 back-to-back beats:
  - Candidate 1 is LVL_ZERO with nonzero components; expect its cand_rate = 0.
  - Beats with sel pattern 0, 2, 1, 2 and selected rates 10, 20, 0, 30.
  - Expect blk_rate = 60 and blk_count = 4, with in_ready held high throughout.
- Saturation:
  - ACC_W = 40. Components all-ones on the selected candidate for 300 beats.
  - Expect each cand_rate = 0xFFFFFFFF with blk_sat = 1.
  - Expect blk_rate clamped at 2^40-1 once exceeded and blk_count = 300.
- Backpressure and clear:
  - Hold blk_ready = 0 for 5 cycles in OUT; expect outputs stable and in_ready = 0.
  - Assert clear mid-ACCUM after 3 beats; expect the next block, 2 beats of 7 each, to give blk_rate = 14 and blk_count = 2.
- Errors:
  - A beat with in_sel = 3 (NUM_CAND = 3): expect 0 added and blk_err = 1.
  - With MAX_COEFFS = 4, send 4 beats without in_last: expect OUT after the 4th beat with blk_count = 4 and blk_err = 1.
- Asynchronous reset while in OUT: expect blk_valid to drop immediately and in_ready = 1.
